button_debounce_multi: RTL and testbench
========================================

# button_debounce_multi

Parametrised, multi-channel successor to the single-button debouncer. Each channel synchronises an asynchronous push-button input, filters it with a run-time programmable stability threshold, and reports the debounced level. It also produces one-cycle press, release and long-press pulses. It sits between the board push-buttons and the APB-side status/interrupt logic.

## Interface
Parameters:
- CHANNELS, 4: number of independent button channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- CNT_W, 16: width of the debounce counter and of debounce_limit.
- HOLD_W, 24: width of the long-press counter and of hold_limit.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- button_push  in  CHANNELS  raw asynchronous button levels, bit i = channel i.
- debounce_limit  in  CNT_W  stability threshold, shared by all channels; quasi-static.
- hold_limit  in  HOLD_W  long-press threshold in cycles, shared; 0 disables long-press.
- button_state  out  CHANNELS  debounced level per channel.
- button_rise  out  CHANNELS  one-cycle pulse when button_state goes 0→1.
- button_fall  out  CHANNELS  one-cycle pulse when button_state goes 1→0.
- button_hold  out  CHANNELS  one-cycle pulse when a press has lasted hold_limit cycles.

## Operation
- All channels are identical and fully independent. No state is shared except the two limit inputs.
- Synchroniser: button_push[i] is shifted through SYNC_STAGES flops; sync[i] is the last stage.
- Debounce counter cnt[i] (CNT_W bits), evaluated every cycle:
  - sync[i] == button_state[i]: cnt ← 0.
  - sync[i] != button_state[i] and cnt < debounce_limit: cnt ← cnt+1.
  - sync[i] != button_state[i] and cnt ≥ debounce_limit: button_state toggles, cnt ← 0.
- Using ≥ guarantees a toggle even if debounce_limit is lowered mid-count. The counter never wraps.
- A glitch shorter than the threshold returns cnt to 0. There is no partial credit.
- button_rise/button_fall are registered alongside the state flop. They are high in exactly the cycle the new button_state is first visible, and never both high at once.
- Long-press counter hold[i] (HOLD_W bits):
  - button_state[i] == 0: hold ← 0.
  - button_state[i] == 1 and hold < hold_limit: hold ← hold+1.
  - Otherwise hold holds, saturating.
- button_hold[i] is registered. It is high for one cycle when hold transitions to equal hold_limit. It fires at most once per press; re-arming requires release.
- hold_limit == 0 means button_hold never asserts.
- Reset: all synchroniser flops, cnt, hold, button_state, button_rise, button_fall and button_hold are 0 on the first rising clk edge with rst=1. rst mid-count discards progress; an input that is still held high is re-qualified from scratch after rst deasserts.

## Timing
- Debounce latency: if button_push changes before edge E and stays stable, button_state changes after edge E + SYNC_STAGES + debounce_limit. With debounce_limit=0, latency is SYNC_STAGES+1 edges.
- Rise/fall pulse width: exactly 1 cycle, coincident with the first cycle of the new level.
- button_hold asserts hold_limit cycles after button_rise, when the press is held continuously.
- An input that changes again during qualification restarts the count in the cycle after sync returns to button_state.
- debounce_limit and hold_limit changes take effect on the next comparison. The limits are not synchronised and must come from the clk domain.

## Test plan
- Reset: drive rst=1 for 2 cycles with button_push=all ones → every output 0. After release with debounce_limit=3, SYNC_STAGES=2: button_state=1111 and button_rise=1111 for 1 cycle, 6 edges after rst deasserts.
- Clean press: channel 0 rises, debounce_limit=10 → button_state[0] rises exactly 2+10+1 cycles later, button_rise[0] is 1 for that cycle only, and other channels stay 0.
- Bounce: channel 1 toggles every 4 cycles for 40 cycles, then holds 1, with debounce_limit=10 → no state change during bouncing; a single rise 13 cycles after the last toggle.
- Long press: hold_limit=50 → button_hold[2] pulses once, 50 cycles after button_rise[2]; no further pulse while held. After release with 13-cycle latency, button_fall[2] pulses once. A second press repeats the hold pulse. With hold_limit=0, no hold pulse occurs.
- Limit edge case: lower debounce_limit from 100 to 5 while cnt=40 → toggle on the next edge, with cnt cleared to 0.
- Mid-operation reset: assert rst while channel 3 is at cnt=7 of 10 and the input stays high → after deassertion, button_state[3] rises only after the full 13-cycle latency.

Source files
------------

// File: rtl/button_debounce_multi_if.sv
// Bus between the push-button front end and the debouncer: raw levels and
// shared limits in, debounced level and edge/long-press pulses out.
interface button_debounce_multi_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int HOLD_W   = 24
);
    logic [CHANNELS-1:0] button_push;
    logic [CNT_W-1:0]    debounce_limit;
    logic [HOLD_W-1:0]   hold_limit;
    logic [CHANNELS-1:0] button_state;
    logic [CHANNELS-1:0] button_rise;
    logic [CHANNELS-1:0] button_fall;
    logic [CHANNELS-1:0] button_hold;

    modport master (
        output button_push, debounce_limit, hold_limit,
        input  button_state, button_rise, button_fall, button_hold
    );

    modport slave (
        input  button_push, debounce_limit, hold_limit,
        output button_state, button_rise, button_fall, button_hold
    );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer: per-channel synchroniser, threshold
// filter with no partial credit, and one-cycle rise/fall/long-press pulses.
module button_debounce_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int HOLD_W      = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debounce_multi_if.slave  bus
);

    // Saturating step of the long-press counter: it stops at the limit so the
    // pulse can only fire on the single transition into equality.
    function automatic logic [HOLD_W-1:0] hold_step(input logic               level,
                                                    input logic [HOLD_W-1:0] cur,
                                                    input logic [HOLD_W-1:0] lim);
        if (!level)
            return '0;
        else if (cur < lim)
            return cur + HOLD_W'(1);
        else
            return cur;
    endfunction

    function automatic logic hold_reached(input logic               level,
                                          input logic [HOLD_W-1:0] cur,
                                          input logic [HOLD_W-1:0] lim);
        return level && (cur < lim) && ((cur + HOLD_W'(1)) == lim);
    endfunction

    logic [CHANNELS-1:0] state_v;
    logic [CHANNELS-1:0] rise_v;
    logic [CHANNELS-1:0] fall_v;
    logic [CHANNELS-1:0] hold_v;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_p0;
        logic                   sync_last;
        logic [CNT_W-1:0]       cnt_p1;
        logic                   state_p1;
        logic                   rise_p1;
        logic                   fall_p1;
        logic                   differ;
        logic                   expired;
        logic [HOLD_W-1:0]      hold_p2;
        logic                   hold_pulse_p2;

        // Stage 0: synchroniser chain, shifting toward the MSB.
        always_ff @(posedge clk) begin
            if (rst)
                sync_p0 <= '0;
            else
                sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.button_push[i]};
        end

        assign sync_last = sync_p0[SYNC_STAGES-1];
        assign differ    = (sync_last != state_p1);
        assign expired   = (cnt_p1 >= bus.debounce_limit);

        // Stage 1: stability counter and debounced level. Using >= means a
        // limit lowered below the running count still produces a toggle.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_p1   <= '0;
                state_p1 <= 1'b0;
                rise_p1  <= 1'b0;
                fall_p1  <= 1'b0;
            end else begin
                rise_p1 <= differ && expired && !state_p1;
                fall_p1 <= differ && expired && state_p1;
                if (!differ) begin
                    cnt_p1 <= '0;
                end else if (!expired) begin
                    cnt_p1 <= cnt_p1 + CNT_W'(1);
                end else begin
                    cnt_p1   <= '0;
                    state_p1 <= ~state_p1;
                end
            end
        end

        // Stage 2: long-press counter, cleared whenever the level is low.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_p2       <= '0;
                hold_pulse_p2 <= 1'b0;
            end else begin
                hold_p2       <= hold_step(state_p1, hold_p2, bus.hold_limit);
                hold_pulse_p2 <= hold_reached(state_p1, hold_p2, bus.hold_limit);
            end
        end

        assign state_v[i] = state_p1;
        assign rise_v[i]  = rise_p1;
        assign fall_v[i]  = fall_p1;
        assign hold_v[i]  = hold_pulse_p2;
    end

    assign bus.button_state = state_v;
    assign bus.button_rise  = rise_v;
    assign bus.button_fall  = fall_v;
    assign bus.button_hold  = hold_v;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: reset vector table, directed corner-case
// sequences and randomized traffic against a behavioural reference model.
module tb_button_debounce_multi;
    localparam int CH = 4;
    localparam int SS = 2;
    localparam int CW = 16;
    localparam int HW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    button_debounce_multi_if #(.CHANNELS(CH), .CNT_W(CW), .HOLD_W(HW)) bus ();

    button_debounce_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .CNT_W(CW), .HOLD_W(HW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the synchronised level is the raw input from SS edges
    // ago; the level flips once the input has disagreed for limit+1 edges in a
    // row; a press fires the long-press pulse when its age equals hold_limit.
    logic [CH-1:0] m_state, m_rise, m_fall, m_hold;
    int            m_run [CH];
    int            m_age [CH];
    logic [CH-1:0] m_hist [$];

    typedef struct {
        logic          rst;
        logic [CH-1:0] push;
        int            dl;
        int            hl;
        logic [CH-1:0] st;
        logic [CH-1:0] ri;
        logic [CH-1:0] fa;
        logic [CH-1:0] ho;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_limits(input int d, input int h);
        bus.debounce_limit = CW'(d);
        bus.hold_limit     = HW'(h);
    endtask

    function automatic logic [CH-1:0] get_out(input int kind);
        case (kind)
            0:       return bus.button_state;
            1:       return bus.button_rise;
            2:       return bus.button_fall;
            default: return bus.button_hold;
        endcase
    endfunction

    task automatic tick();
        logic [CH-1:0] pin;
        logic [CH-1:0] s;
        logic          r;
        int            dl;
        int            hl;
        pin = bus.button_push;
        r   = rst;
        dl  = int'(bus.debounce_limit);
        hl  = int'(bus.hold_limit);
        @(posedge clk);
        if (r) begin
            m_state = '0; m_rise = '0; m_fall = '0; m_hold = '0;
            for (int i = 0; i < CH; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
            m_hist = {};
            for (int k = 0; k < SS; k++) m_hist.push_back('0);
        end else begin
            s = m_hist.pop_front();
            m_hist.push_back(pin);
            for (int i = 0; i < CH; i++) begin
                m_hold[i] = 1'b0;
                if (m_state[i]) begin
                    m_age[i]++;
                    if (hl != 0 && m_age[i] == hl) m_hold[i] = 1'b1;
                end else begin
                    m_age[i] = 0;
                end
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (s[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] > dl) begin
                        m_rise[i]  = ~m_state[i];
                        m_fall[i]  = m_state[i];
                        m_state[i] = ~m_state[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        #1;
        check("model", {16'h0, bus.button_state, bus.button_rise, bus.button_fall, bus.button_hold},
              {16'h0, m_state, m_rise, m_fall, m_hold});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Ticks until output 'kind' bit ch equals val; n = ticks taken, -1 on timeout.
    task automatic count_until(input int kind, input int ch, input logic val,
                               input int maxc, output int n);
        logic [CH-1:0] v;
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            v = get_out(kind);
            if (v[ch] === val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int kind, input int ch, input int cycles, output int n);
        logic [CH-1:0] v;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            v = get_out(kind);
            if (v[ch] === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [CH-1:0] v;

        m_state = '0; m_rise = '0; m_fall = '0; m_hold = '0;
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0;
            m_age[i] = 0;
        end
        for (int k = 0; k < SS; k++) m_hist.push_back('0);
        rst = 1'b1;
        bus.button_push = '0;
        set_limits(3, 0);

        // Reset with all buttons high, then qualification with limit 3.
        tbl[0] = '{1'b1, 4'hF, 3, 0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{1'b1, 4'hF, 3, 0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int k = 2; k < 7; k++)
            tbl[k] = '{1'b0, 4'hF, 3, 0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[7] = '{1'b0, 4'hF, 3, 0, 4'hF, 4'hF, 4'h0, 4'h0};
        tbl[8] = '{1'b0, 4'hF, 3, 0, 4'hF, 4'h0, 4'h0, 4'h0};

        for (int k = 0; k < 9; k++) begin
            rst = tbl[k].rst;
            bus.button_push = tbl[k].push;
            set_limits(tbl[k].dl, tbl[k].hl);
            tick();
            check($sformatf("vec%0d", k),
                  {16'h0, bus.button_state, bus.button_rise, bus.button_fall, bus.button_hold},
                  {16'h0, tbl[k].st, tbl[k].ri, tbl[k].fa, tbl[k].ho});
        end

        // Clean press on channel 0.
        bus.button_push = '0;
        set_limits(10, 0);
        do_reset();
        bus.button_push = 4'b0001;
        count_until(0, 0, 1'b1, 100, n);
        check("clean_latency", n, 13);
        v = bus.button_rise;
        check("clean_rise", {28'h0, v}, 32'h1);
        v = bus.button_state;
        check("clean_others", {28'h0, v}, 32'h1);
        tick();
        v = bus.button_rise;
        check("clean_rise_end", {28'h0, v}, 32'h0);

        // Bounce on channel 1: toggle every 4 cycles for 40 cycles, then hold.
        bus.button_push = '0;
        do_reset();
        cnt = 0;
        for (int seg = 0; seg < 10; seg++) begin
            bus.button_push[1] = (seg % 2 == 0);
            for (int k = 0; k < 4; k++) begin
                tick();
                v = bus.button_state | bus.button_rise | bus.button_fall;
                if (v[1]) cnt++;
            end
        end
        check("bounce_quiet", cnt, 0);
        bus.button_push[1] = 1'b1;
        count_until(1, 1, 1'b1, 100, n);
        check("bounce_latency", n, 13);
        count_pulses(1, 1, 30, n);
        check("bounce_single_rise", n, 0);

        // Long press on channel 2.
        bus.button_push = '0;
        set_limits(10, 50);
        do_reset();
        bus.button_push[2] = 1'b1;
        count_until(1, 2, 1'b1, 100, n);
        check("long_rise", n, 13);
        count_until(3, 2, 1'b1, 200, n);
        check("long_hold_delay", n, 50);
        count_pulses(3, 2, 100, n);
        check("long_hold_once", n, 0);
        bus.button_push[2] = 1'b0;
        count_until(2, 2, 1'b1, 100, n);
        check("long_fall", n, 13);
        count_pulses(2, 2, 20, n);
        check("long_fall_once", n, 0);
        bus.button_push[2] = 1'b1;
        count_until(1, 2, 1'b1, 100, n);
        check("long_rise2", n, 13);
        count_until(3, 2, 1'b1, 200, n);
        check("long_hold2", n, 50);
        bus.button_push[2] = 1'b0;
        count_until(2, 2, 1'b1, 100, n);
        check("long_fall2", n, 13);
        tick();
        tick();
        set_limits(10, 0);
        bus.button_push[2] = 1'b1;
        count_pulses(3, 2, 200, n);
        check("hold_disabled", n, 0);

        // Lowering the limit below the running count toggles on the next edge.
        bus.button_push = '0;
        set_limits(100, 0);
        do_reset();
        bus.button_push[3] = 1'b1;
        repeat (42) tick();
        v = bus.button_state;
        check("limit_before", {31'h0, v[3]}, 32'h0);
        set_limits(5, 0);
        tick();
        v = bus.button_state;
        check("limit_toggle", {31'h0, v[3]}, 32'h1);
        v = bus.button_rise;
        check("limit_rise", {31'h0, v[3]}, 32'h1);
        bus.button_push[3] = 1'b0;
        count_until(0, 3, 1'b0, 100, n);
        check("limit_release", n, 8);

        // Reset mid-count discards progress on channel 3.
        bus.button_push = '0;
        set_limits(10, 0);
        do_reset();
        bus.button_push[3] = 1'b1;
        repeat (9) tick();
        v = bus.button_state;
        check("midrst_before", {31'h0, v[3]}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_until(0, 3, 1'b1, 100, n);
        check("midrst_latency", n, 13);

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 4; seg++) begin
            bus.button_push = '0;
            set_limits(int'($urandom_range(0, 6)), int'($urandom_range(0, 20)));
            do_reset();
            for (int k = 0; k < 300; k++) begin
                for (int i = 0; i < CH; i++)
                    if ($urandom_range(0, 5) == 0) bus.button_push[i] = ~bus.button_push[i];
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
